// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with 2-entry skid buffer and stall counter
module pipe_stage_skid #(
  parameter int                 DATA_W = 160,
  parameter logic [DATA_W-1:0]  BUBBLE = '0,
  parameter int                 CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                in_ready_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic                accept;
  logic                consume;

  // in_ready_q is kept equal to (state_q != FULL), so no accept can occur in FULL
  assign accept    = in_valid & in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign consume   = out_valid & out_ready;

  assign in_ready  = in_ready_q;
  assign out_data  = out_valid ? main_q : BUBBLE;
  assign occupancy = 2'(state_q);
  assign stall_cnt = stall_cnt_q;

  // Next-state and payload steering; flush overrides every handshake outcome
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_d = in_data;
        end else if (consume) begin
          state_d = EMPTY;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_data;
        end
      end
      FULL: begin
        if (consume) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end
  end

  // State, payload and registered in_ready; reset drops everything held
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Saturating count of cycles where downstream holds off a valid beat; flush leaves it alone
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int DW = 160;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          in_ready4;
  logic          out_valid4;
  logic [DW-1:0] out_data4;
  logic [1:0]    occupancy4;
  logic [3:0]    stall_cnt4;

  int errors;
  int checks;

  localparam logic [DW-1:0] A = 160'hAAAA_0001;
  localparam logic [DW-1:0] B = 160'hBBBB_0002;
  localparam logic [DW-1:0] C = 160'hCCCC_0003;
  localparam logic [DW-1:0] D = 160'hDDDD_0004;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one clock edge, sampling resumes on the following falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    reset = 1'b1;
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data = DW'(k);
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid beat=%0d got=%b exp=1", k, out_valid); end
      checks++; if (out_data !== DW'(k)) begin errors++; $display("FAIL stream_data beat=%0d got=%h exp=%h", k, out_data, DW'(k)); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ beat=%0d got=%0d exp=1", k, occupancy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat=%0d got=%b exp=1", k, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain_occ got=%0d exp=0", occupancy); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL stream_drain_data got=%h exp=0", out_data); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = A;
    tick();
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ_a got=%0d exp=1", occupancy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL bp_stall_a got=%0d exp=0", stall_cnt); end
    in_data = B;
    tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ_full got=%0d exp=2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL bp_stall_b got=%0d exp=1", stall_cnt); end
    in_data = C;
    repeat (5) tick();
    checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL bp_stall_hold got=%0d exp=6", stall_cnt); end
    checks++; if (out_data !== A) begin errors++; $display("FAIL bp_head_a got=%h exp=%h", out_data, A); end
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ_hold got=%0d exp=2", occupancy); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== B) begin errors++; $display("FAIL bp_second_b got=%h exp=%h", out_data, B); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ_after_a got=%0d exp=1", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_reopen got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_data !== C) begin errors++; $display("FAIL bp_third_c got=%h exp=%h", out_data, C); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ_c got=%0d exp=1", occupancy); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got=%b exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL bp_stall_final got=%0d exp=6", stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = A;
    tick();
    in_data = B;
    tick();
    in_data = D; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL flush_data got=%h exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_keeps_stall got=%0d exp=2", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_d cycle=%0d got=%b data=%h exp=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = A;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    checks++; if (stall_cnt4 !== 4'd14) begin errors++; $display("FAIL sat_pre got=%0d exp=14", stall_cnt4); end
    repeat (6) tick();
    checks++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_clamp got=%0d exp=15", stall_cnt4); end
    checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
    tick();
    checks++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt4); end
    checks++; if (out_data4 !== A) begin errors++; $display("FAIL sat_payload got=%h exp=%h", out_data4, A); end
  endtask

  task automatic test_reset_full();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = A;
    tick();
    in_data = B;
    tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rstfull_pre_occ got=%0d exp=2", occupancy); end
    in_data = D; flush = 1'b1; reset = 1'b0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstfull_in_ready got=%b exp=1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rstfull_occ got=%0d exp=0", occupancy); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rstfull_data got=%h exp=0", out_data); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rstfull_stall got=%0d exp=0", stall_cnt); end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_survivor cycle=%0d got=%b data=%h exp=0", i, out_valid, out_data); end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_saturation();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
